// File: rtl/dfr_pkg.sv
// -----------------------------------------------------------------------------
// dfr_pkg
// Shared definitions for the DFR reservoir sequencer:
//   - state encoding of the sample sequencer FSM
//   - neg_sat(): two's complement negation that saturates the most-negative
//     value to the most-positive one, instead of wrapping back to itself
// -----------------------------------------------------------------------------
package dfr_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DRIVE   = 3'd1;
  localparam logic [2:0] ST_CONVERT = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_VALID   = 3'd4;

  // Widest data word neg_sat() can handle
  localparam int unsigned DFR_MAX_WIDTH = 64;

  // Negate a 'width'-bit two's complement value that has been sign-extended
  // to 64 bits. The most-negative value has no positive counterpart, so it
  // maps to the most-positive value. The caller truncates back to 'width'.
  function automatic logic [63:0] neg_sat(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_v;
    logic [63:0] min_v;
    max_v = (64'd1 << (width - 32'd1)) - 64'd1;
    min_v = ~max_v;
    if (value == min_v) begin
      neg_sat = max_v;
    end else begin
      neg_sat = ~value + 64'd1;
    end
  endfunction

endpackage

// File: rtl/dfr_settle_timer.sv
// -----------------------------------------------------------------------------
// dfr_settle_timer
// Loadable down-counter used to hold the DAC for a fixed number of cycles.
// Loading N gives N+1 cycles until done (done is high while the count is 0).
// Ports:
//   clk        system clock
//   rst        synchronous active-high clear (count -> 0)
//   load       load load_value (takes priority over dec)
//   load_value value loaded on load
//   dec        decrement by one while nonzero
//   done       count is zero
// -----------------------------------------------------------------------------
module dfr_settle_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count_r;

  // Down-counter with load priority; stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - WIDTH'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/dfr_reservoir_sequencer.sv
// -----------------------------------------------------------------------------
// dfr_reservoir_sequencer
// Responder side of the DFR core control handshake. Each accepted
// reservoir_en latches one sample, which is then time-multiplexed over
// VIRTUAL_NODES virtual nodes: for every node the masked sample is driven to
// the DAC for NODE_SETTLE_CYCLES cycles, one ADC conversion is requested, and
// the converted value is written to node memory. A one-cycle reservoir_valid
// marks the end of each sample. Status flags are decoded from the number of
// completed samples.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   reservoir_rst       synchronous run clear, same effect as rst
//   reservoir_en        1-cycle request to process sample_in
//   sample_in, mask     sample word and per-node sign mask (1:+s, 0:-s)
//   reservoir_busy      fewer than NUM_SAMPLES samples done
//   reservoir_init_busy fewer than NUM_INIT_SAMPLES samples done
//   reservoir_filled    more than NUM_INIT_SAMPLES samples done
//   reservoir_valid     1-cycle pulse, sample fully written
//   dac_data, dac_valid masked sample for the current node, high in DRIVE
//   adc_start           1-cycle conversion request
//   adc_done, adc_data  conversion complete / converted value
//   node_wr_en, node_addr, node_data   node memory write port
// -----------------------------------------------------------------------------
module dfr_reservoir_sequencer
  import dfr_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int VIRTUAL_NODES      = 10,
  parameter int NUM_INIT_SAMPLES   = 3,
  parameter int NUM_SAMPLES        = 8,
  parameter int NODE_SETTLE_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             reservoir_rst,
  input  logic                             reservoir_en,
  input  logic [DATA_WIDTH-1:0]            sample_in,
  input  logic [VIRTUAL_NODES-1:0]         mask,
  output logic                             reservoir_busy,
  output logic                             reservoir_init_busy,
  output logic                             reservoir_filled,
  output logic                             reservoir_valid,
  output logic [DATA_WIDTH-1:0]            dac_data,
  output logic                             dac_valid,
  output logic                             adc_start,
  input  logic                             adc_done,
  input  logic [DATA_WIDTH-1:0]            adc_data,
  output logic                             node_wr_en,
  output logic [$clog2(VIRTUAL_NODES)-1:0] node_addr,
  output logic [DATA_WIDTH-1:0]            node_data
);

  localparam int unsigned ADDR_W  = $clog2(VIRTUAL_NODES);
  localparam int unsigned CNT_W   = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned TIMER_W = (NODE_SETTLE_CYCLES > 1) ? $clog2(NODE_SETTLE_CYCLES) : 1;

  localparam logic [ADDR_W-1:0]  LAST_NODE   = ADDR_W'(VIRTUAL_NODES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0]   CNT_INIT    = CNT_W'(NUM_INIT_SAMPLES);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(NODE_SETTLE_CYCLES - 1);

  // State, node counter, latched sample, completed-sample counter
  logic [2:0]            state_r,  state_nx_s;
  logic [ADDR_W-1:0]     node_r,   node_nx_s;
  logic [DATA_WIDTH-1:0] sample_r, sample_nx_s;
  logic [CNT_W-1:0]      cnt_r,    cnt_nx_s;

  // Registered outputs and their next values
  logic                  dac_valid_r,       dac_valid_nx_s;
  logic [DATA_WIDTH-1:0] dac_data_r,        dac_data_nx_s;
  logic                  adc_start_r,       adc_start_nx_s;
  logic                  node_wr_en_r,      node_wr_en_nx_s;
  logic [ADDR_W-1:0]     node_addr_r,       node_addr_nx_s;
  logic [DATA_WIDTH-1:0] node_data_r,       node_data_nx_s;
  logic                  reservoir_valid_r, reservoir_valid_nx_s;

  logic                  clear_s;
  logic                  capture_s;
  logic                  timer_load_s;
  logic                  timer_dec_s;
  logic                  timer_done_s;
  logic [DATA_WIDTH-1:0] neg_sample_s;

  assign clear_s = rst | reservoir_rst;

  assign reservoir_busy      = (cnt_r < CNT_MAX);
  assign reservoir_init_busy = (cnt_r < CNT_INIT);
  assign reservoir_filled    = (cnt_r > CNT_INIT);

  // Negated sample for mask bit 0; uses the sample that will be driven next
  assign neg_sample_s = DATA_WIDTH'(neg_sat(64'($signed(sample_nx_s)), DATA_WIDTH));

  // Reload the hold timer on every entry into DRIVE, count down while in it
  assign timer_load_s = (state_nx_s == ST_DRIVE) && (state_r != ST_DRIVE);
  assign timer_dec_s  = (state_r == ST_DRIVE);

  dfr_settle_timer #(
    .WIDTH (TIMER_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (clear_s),
    .load       (timer_load_s),
    .load_value (SETTLE_LOAD),
    .dec        (timer_dec_s),
    .done       (timer_done_s)
  );

  // Next-state logic for the sequencer FSM and its counters
  always_comb begin
    state_nx_s  = state_r;
    node_nx_s   = node_r;
    sample_nx_s = sample_r;
    cnt_nx_s    = cnt_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Requests after the run is complete are dropped without effect
        if (reservoir_en && reservoir_busy) begin
          sample_nx_s = sample_in;
          node_nx_s   = {ADDR_W{1'b0}};
          state_nx_s  = ST_DRIVE;
        end else begin
          state_nx_s  = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (timer_done_s) begin
          state_nx_s = ST_CONVERT;
        end else begin
          state_nx_s = ST_DRIVE;
        end
      end
      ST_CONVERT: begin
        // adc_start_r is high only on the entry cycle, so a done seen
        // together with our own request is a stale one and is ignored
        if (adc_done && !adc_start_r) begin
          capture_s  = 1'b1;
          state_nx_s = ST_WRITE;
        end else begin
          state_nx_s = ST_CONVERT;
        end
      end
      ST_WRITE: begin
        if (node_r == LAST_NODE) begin
          state_nx_s = ST_VALID;
        end else begin
          node_nx_s  = node_r + ADDR_W'(1'b1);
          state_nx_s = ST_DRIVE;
        end
      end
      ST_VALID: begin
        state_nx_s = ST_IDLE;
        if (cnt_r < CNT_MAX) begin
          cnt_nx_s = cnt_r + CNT_W'(1'b1);
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so registered outputs line up with it
  always_comb begin
    dac_valid_nx_s       = (state_nx_s == ST_DRIVE);
    adc_start_nx_s       = (state_nx_s == ST_CONVERT) && (state_r != ST_CONVERT);
    node_wr_en_nx_s      = (state_nx_s == ST_WRITE);
    reservoir_valid_nx_s = (state_nx_s == ST_VALID);
    if (state_nx_s == ST_DRIVE) begin
      if (mask[node_nx_s]) begin
        dac_data_nx_s = sample_nx_s;
      end else begin
        dac_data_nx_s = neg_sample_s;
      end
    end else begin
      dac_data_nx_s = {DATA_WIDTH{1'b0}};
    end
    if (state_nx_s == ST_WRITE) begin
      node_addr_nx_s = node_nx_s;
    end else begin
      node_addr_nx_s = {ADDR_W{1'b0}};
    end
    // node_data doubles as the capture register: loaded on the accepted
    // adc_done and presented during the single WRITE cycle
    if (capture_s) begin
      node_data_nx_s = adc_data;
    end else begin
      node_data_nx_s = {DATA_WIDTH{1'b0}};
    end
  end

  // State, counters and registered outputs; either reset source clears everything
  always_ff @(posedge clk) begin
    if (clear_s) begin
      state_r           <= ST_IDLE;
      node_r            <= {ADDR_W{1'b0}};
      sample_r          <= {DATA_WIDTH{1'b0}};
      cnt_r             <= {CNT_W{1'b0}};
      dac_valid_r       <= 1'b0;
      dac_data_r        <= {DATA_WIDTH{1'b0}};
      adc_start_r       <= 1'b0;
      node_wr_en_r      <= 1'b0;
      node_addr_r       <= {ADDR_W{1'b0}};
      node_data_r       <= {DATA_WIDTH{1'b0}};
      reservoir_valid_r <= 1'b0;
    end else begin
      state_r           <= state_nx_s;
      node_r            <= node_nx_s;
      sample_r          <= sample_nx_s;
      cnt_r             <= cnt_nx_s;
      dac_valid_r       <= dac_valid_nx_s;
      dac_data_r        <= dac_data_nx_s;
      adc_start_r       <= adc_start_nx_s;
      node_wr_en_r      <= node_wr_en_nx_s;
      node_addr_r       <= node_addr_nx_s;
      node_data_r       <= node_data_nx_s;
      reservoir_valid_r <= reservoir_valid_nx_s;
    end
  end

  assign dac_valid       = dac_valid_r;
  assign dac_data        = dac_data_r;
  assign adc_start       = adc_start_r;
  assign node_wr_en      = node_wr_en_r;
  assign node_addr       = node_addr_r;
  assign node_data       = node_data_r;
  assign reservoir_valid = reservoir_valid_r;

endmodule
